// File: rtl/ifetch.sv
// ifetch -- instruction fetch unit.
//
// Owns the fetch program counter and reads 8-bit instructions from a
// request/acknowledge memory port. Up to two prefetched instructions are
// held in a small FIFO and the oldest is presented to the controller.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   fetch          controller consumes the head instruction (ignored when
//                  nothing is valid)
//   jmp, jmp_addr  single-cycle redirect: flush the buffer, refetch at jmp_addr
//   instr, pc      head instruction and its address
//   instr_valid    instr/pc are meaningful
//   mem_req        registered read request, held until mem_ack
//   mem_addr       registered read address, stable while mem_req is high
//   mem_data       read data, taken on the edge where mem_req & mem_ack
//   mem_ack        read completion
module ifetch #(
  parameter logic [15:0] RST_VEC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch,
  input  logic        jmp,
  input  logic [15:0] jmp_addr,
  output logic [7:0]  instr,
  output logic        instr_valid,
  output logic [15:0] pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  count;
  logic [15:0] fpc, fpc_nxt;
  logic        mem_req_nxt;
  logic [15:0] mem_addr_nxt;

  // Entry 0 is the head; entry 1 is the younger instruction.
  logic [15:0] ent_addr [2];
  logic [7:0]  ent_data [2];

  logic        pop, push, room;
  logic [1:0]  kept;
  logic [1:0]  level;

  assign instr_valid = (count != 2'd0);
  assign instr       = ent_data[0];
  assign pc          = ent_addr[0];

  assign pop  = fetch & instr_valid & ~jmp;
  assign push = mem_req & mem_ack & (state == BUSY) & ~jmp;

  // kept = entries surviving this edge before the push lands; it also
  // selects the slot the pushed entry is written into. A request is only
  // in flight while count <= 1, so level never exceeds 2.
  assign kept  = count - {1'b0, pop};
  assign level = kept + {1'b0, push};
  assign room  = (level < 2'd2);

  // Request FSM and fetch pointer next-state logic.
  always_comb begin
    state_nxt    = state;
    mem_req_nxt  = mem_req;
    mem_addr_nxt = mem_addr;
    fpc_nxt      = fpc;

    if (push) begin
      fpc_nxt = fpc + 16'd1;
    end
    if (jmp) begin
      fpc_nxt = jmp_addr;
    end

    case (state)
      IDLE: begin
        // A jump seen in IDLE only moves fpc; the request follows next edge.
        if (!jmp && room) begin
          mem_req_nxt  = 1'b1;
          mem_addr_nxt = fpc;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        if (jmp) begin
          // An ack on the jump edge is simply discarded; otherwise the
          // outstanding request must still be drained in DROP.
          if (mem_ack) begin
            mem_req_nxt = 1'b0;
            state_nxt   = IDLE;
          end else begin
            state_nxt = DROP;
          end
        end else if (mem_ack) begin
          if (room) begin
            mem_addr_nxt = fpc + 16'd1;
          end else begin
            mem_req_nxt = 1'b0;
            state_nxt   = IDLE;
          end
        end
      end
      DROP: begin
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end
      default: begin
        mem_req_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  // Registered FSM state, memory port and fetch pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= RST_VEC;
      fpc      <= RST_VEC;
    end else begin
      state    <= state_nxt;
      mem_req  <= mem_req_nxt;
      mem_addr <= mem_addr_nxt;
      fpc      <= fpc_nxt;
    end
  end

  // Occupancy counter; a jump empties the buffer.
  always_ff @(posedge clk) begin
    if (rst || jmp) begin
      count <= 2'd0;
    end else begin
      count <= level;
    end
  end

  // Buffer storage. A pop shifts entry 1 into the head; a push then writes
  // behind whatever survived, so with count=1 and push+pop together the new
  // entry overwrites the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_addr[0] <= RST_VEC;
      ent_addr[1] <= RST_VEC;
      ent_data[0] <= 8'h00;
      ent_data[1] <= 8'h00;
    end else if (!jmp) begin
      if (pop) begin
        ent_addr[0] <= ent_addr[1];
        ent_data[0] <= ent_data[1];
      end
      if (push) begin
        if (kept == 2'd0) begin
          ent_addr[0] <= mem_addr;
          ent_data[0] <= mem_data;
        end else begin
          ent_addr[1] <= mem_addr;
          ent_data[1] <= mem_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch -- self-checking bench for ifetch.
//
// A memory responder returns addr[7:0] as data after a programmable number
// of wait cycles. The driver pushes the expected (pc, instr) sequence into a
// queue; a monitor pops and compares every time the controller side
// consumes an instruction, and also checks that an unacknowledged request
// keeps mem_req and mem_addr stable.
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic        fetch;
  logic        jmp;
  logic [15:0] jmp_addr;
  logic [7:0]  instr;
  logic        instr_valid;
  logic [15:0] pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   wait_n = 0;
  int   wcnt = 0;
  int   ack_count = 0;
  int   used;

  ifetch #(.RST_VEC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch       (fetch),
    .jmp         (jmp),
    .jmp_addr    (jmp_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: ack after wait_n cycles of a held request.
  initial begin
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    forever begin
      @(negedge clk);
      mem_data = mem_addr[7:0];
      mem_ack  = (mem_req === 1'b1) && (wcnt >= wait_n);
      if (mem_req === 1'b1 && mem_ack) begin
        wcnt = 0;
        ack_count++;
      end else if (mem_req === 1'b1) begin
        wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: scoreboard compare on every consumption, plus request hold check.
  initial begin
    logic        prev_wait;
    logic        prev_rst;
    logic [15:0] prev_addr;
    exp_t        e;
    prev_wait = 1'b0;
    prev_rst  = 1'b1;
    prev_addr = 16'h0000;
    forever begin
      @(negedge clk);
      #1;
      if (prev_wait && !prev_rst) begin
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
          fails++;
          $display("[TB] FAIL req_hold: mem_req=%b mem_addr=%h, required mem_req=1 mem_addr=%h",
                   mem_req, mem_addr, prev_addr);
        end
      end
      prev_wait = (mem_req === 1'b1) && (mem_ack !== 1'b1);
      prev_addr = mem_addr;
      prev_rst  = rst;
      if (!rst && fetch && !jmp && instr_valid === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_instr: pc=%h instr=%h, required no consumption", pc, instr);
        end else begin
          e = exp_q.pop_front();
          if (pc !== e.pc || instr !== e.data) begin
            fails++;
            $display("[TB] FAIL stream: pc=%h instr=%h, required pc=%h instr=%h",
                     pc, instr, e.pc, e.data);
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic r, input logic f, input logic j,
                               input logic [15:0] ja);
    @(negedge clk);
    rst      = r;
    fetch    = f;
    jmp      = j;
    jmp_addr = ja;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic pushExpected(input logic [15:0] p, input logic [7:0] d);
    exp_t e;
    e.pc   = p;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic resetDut(input int w);
    wait_n = w;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
  endtask

  // Fetch every cycle until the scoreboard is empty; n = cycles spent.
  task automatic drain(input int budget, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst      = 1'b1;
    fetch    = 1'b0;
    jmp      = 1'b0;
    jmp_addr = 16'h0000;

    // Reset values, then a zero-wait stream popped every cycle.
    resetDut(0);
    checkOutput("rst_mem_req", 16'(mem_req), 16'h0);
    checkOutput("rst_mem_addr", mem_addr, 16'h0000);
    checkOutput("rst_instr", 16'(instr), 16'h0);
    checkOutput("rst_valid", 16'(instr_valid), 16'h0);
    checkOutput("rst_pc", pc, 16'h0000);
    for (int i = 0; i < 10; i++) pushExpected(16'(i), 8'(i));
    drain(40, used);
    checkOutput("zw_cycles", 16'(used), 16'd12);

    // Three wait states: one instruction every four cycles.
    resetDut(3);
    for (int i = 0; i < 5; i++) pushExpected(16'(i), 8'(i));
    drain(60, used);
    checkOutput("ws_cycles", 16'(used), 16'd22);

    // Buffer full with no consumption, then a single fetch pulse.
    resetDut(0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    ack_count = 0;
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("full_acks", 16'(ack_count), 16'd2);
    checkOutput("full_mem_req", 16'(mem_req), 16'h0);
    checkOutput("full_valid", 16'(instr_valid), 16'h1);
    checkOutput("full_pc", pc, 16'h0000);
    pushExpected(16'h0000, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("refill_req", 16'(mem_req), 16'h1);
    checkOutput("refill_addr", mem_addr, 16'h0002);
    for (int i = 1; i < 4; i++) pushExpected(16'(i), 8'(i));
    drain(20, used);

    // Jump while a request is waiting for its ack.
    resetDut(2);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("jw_valid", 16'(instr_valid), 16'h1);
    checkOutput("jw_mem_addr", mem_addr, 16'h0001);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("drop_valid", 16'(instr_valid), 16'h0);
    checkOutput("drop_req", 16'(mem_req), 16'h1);
    checkOutput("drop_addr", mem_addr, 16'h0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("post_drop_req", 16'(mem_req), 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("jmp_req", 16'(mem_req), 16'h1);
    checkOutput("jmp_addr", mem_addr, 16'h1234);
    pushExpected(16'h1234, 8'h34);
    pushExpected(16'h1235, 8'h35);
    drain(30, used);

    // Jump from IDLE to FFFE and stream across the wrap.
    resetDut(0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFE);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("wrap_idle_req", 16'(mem_req), 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("wrap_req", 16'(mem_req), 16'h1);
    checkOutput("wrap_addr", mem_addr, 16'hFFFE);
    pushExpected(16'hFFFE, 8'hFE);
    pushExpected(16'hFFFF, 8'hFF);
    pushExpected(16'h0000, 8'h00);
    pushExpected(16'h0001, 8'h01);
    drain(20, used);
    checkOutput("wrap_cycles", 16'(used), 16'd4);

    // Reset in BUSY with count=1 and an ack on the same edge.
    resetDut(0);
    for (int i = 0; i < 3; i++) pushExpected(16'(i), 8'(i));
    drain(20, used);
    checkOutput("pre_rst_cycles", 16'(used), 16'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("pre_rst_pc", pc, 16'h0003);
    checkOutput("pre_rst_ack", 16'(mem_req & mem_ack), 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("mid_rst_req", 16'(mem_req), 16'h0);
    checkOutput("mid_rst_valid", 16'(instr_valid), 16'h0);
    checkOutput("mid_rst_pc", pc, 16'h0000);
    checkOutput("mid_rst_instr", 16'(instr), 16'h0);
    pushExpected(16'h0000, 8'h00);
    pushExpected(16'h0001, 8'h01);
    drain(20, used);

    checkOutput("scoreboard_empty", 16'(exp_q.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit: owns the fetch program counter and reads 8-bit instructions from the memory port. It holds up to two prefetched instructions and presents the oldest to the controller on `instr`. The block sits directly upstream of the controller. It advances when the controller asserts `fetch`, and it flushes and redirects on `jmp`.

## Interface
- `RST_VEC`, 16'h0000: fetch address loaded on reset.
- `clk`  in  1: clock; all state updates on posedge.
- `rst`  in  1: reset, synchronous, active-high.
- `fetch`  in  1: controller consumes the current instruction. Honoured only when `instr_valid`=1.
- `jmp`  in  1: redirect request; single-cycle pulse.
- `jmp_addr`  in  16: redirect target.
- `instr`  out  8: head-of-buffer instruction.
- `instr_valid`  out  1: `instr` and `pc` are meaningful.
- `pc`  out  16: address of `instr`.
- `mem_req`  out  1: read request, registered.
- `mem_addr`  out  16: read address, registered.
- `mem_data`  in  8: read data, sampled on the edge where `mem_req`&`mem_ack`.
- `mem_ack`  in  1: read completion.

## Operation
- **Buffer:** 2-entry FIFO. Each entry holds {addr[15:0], data[7:0]}. A 2-bit count runs 0..2. `instr`/`pc` come from the head entry; `instr_valid` = (count != 0).
- **pop** = `fetch` & `instr_valid` & !`jmp`. `fetch` with `instr_valid`=0 is ignored; no state change.
- **push** = `mem_req` & `mem_ack` & (state == BUSY) & !`jmp`. The pushed entry is {`mem_addr`, `mem_data`}.
- **Simultaneous push and pop:** count is unchanged. The new entry lands behind the surviving one, or at the head if count was 1.
- **Fetch pointer `fpc`:** 16 bits, incremented by 1 on each push. It wraps 16'hFFFF -> 16'h0000 with no flag.
- **Room:** room = (count + push - pop) < 2. At most one request is outstanding.
- **FSM states:** IDLE, BUSY, DROP.
  - IDLE: if room, then `mem_req`<=1, `mem_addr`<=`fpc`, go to BUSY.
  - BUSY: `mem_req` stays high and `mem_addr` stays stable until `mem_ack`. On ack, push. If room remains after this edge, issue the next request back-to-back (`mem_addr`<=`fpc`+1, `mem_req` stays 1, stay in BUSY). Otherwise `mem_req`<=0 and go to IDLE.
  - DROP: `mem_req` stays high with the old `mem_addr`. On `mem_ack`, the data is discarded, `mem_req`<=0, and the FSM goes to IDLE.
- **jmp (highest priority after rst):**
  - Count <= 0, `fpc` <= `jmp_addr`.
  - If state is BUSY and `mem_ack`=0 that cycle, go to DROP. If `mem_ack`=1 that cycle, the data is discarded, `mem_req`<=0, and the FSM goes to IDLE.
  - From IDLE: stays IDLE; the request to `jmp_addr` issues on the next edge.
  - `jmp` during DROP: updates `fpc` only and stays in DROP.
- **rst:** overrides everything. Count <= 0, `fpc` <= `RST_VEC`, state <= IDLE, `mem_req` <= 0.
  - An ack arriving on the rst edge is ignored.
  - The memory side must tolerate a request abandoned by reset.

## Timing
- **Reset values:** `mem_req`=0, `mem_addr`=`RST_VEC`, `instr`=8'h00, `instr_valid`=0, `pc`=`RST_VEC`. Buffer data is cleared to 0.
- **Cycle after reset release (c0):** IDLE with room, so `mem_req`=1 and `mem_addr`=`RST_VEC` from c1.
- **Zero-wait memory (`mem_ack` high when `mem_req` high):** data captured at the end of c1, `instr_valid`=1 in c2. Sustained throughput is 1 instruction/cycle while the controller pops every cycle.
- **N wait cycles:** latency grows by N. `mem_addr` must not change between request and ack.
- **Buffer full (count=2, no pop):** `mem_req` drops after the second ack. It re-asserts in the cycle after the first pop.
- **Jump to first valid instruction:** `jmp` in cycle j, then `mem_req` at `jmp_addr` in j+2 (via IDLE), then `instr_valid` in j+3 with zero-wait memory. A DROP adds the remaining wait cycles plus 1.
- **Outputs:** all registered or derived from registered state only. There is no combinational path from `fetch`, `jmp` or `mem_ack` to any output.

## Test plan
- **Reset and zero-wait stream:** release rst, `mem_ack`=1, memory returns addr[7:0], `fetch`=1 continuously -> `instr` 8'h00, 8'h01, 8'h02… on consecutive cycles from c2, `pc` 0,1,2…
- **Wait states:** `mem_ack` asserted 3 cycles after each `mem_req` -> `mem_addr` held stable during wait, one instruction every 4 cycles, no duplicates or skips.
- **Buffer full:** `fetch`=0 with zero-wait memory -> exactly two acks, `mem_req`=0, `pc`=`RST_VEC`. A single `fetch` pulse then re-issues the request for address 2 on the next cycle.
- **Jump with outstanding request:** `mem_ack` delayed 2 cycles, `jmp`=1 with `jmp_addr`=16'h1234 mid-wait -> old ack discarded, next `mem_addr`=16'h1234, first valid `pc`=16'h1234. A simultaneous `fetch` has no effect.
- **Wrap-around:** `jmp_addr`=16'hFFFE, stream -> `pc` sequence FFFE, FFFF, 0000, 0001.
- **Reset mid-operation:** rst asserted while in BUSY and count=1, with `mem_ack`=1 on the same edge -> next cycle `mem_req`=0, `instr_valid`=0, `pc`=`RST_VEC`, data not pushed.
